// File: rtl/frame_arb_mport.sv
// frame_arb_mport: N-port frame arbiter feeding the array controller.
// Selects one eligible source at a time, holds the grant from sof to eof,
// drops the len field and presents beats through a registered output stage.
module frame_arb_mport #(
    parameter int NUM_PORTS = 4,
    parameter int COL_W     = 6,
    parameter int ROW_W     = 16,
    parameter int LEN_W     = 8,
    parameter int DATA_W    = 64,
    parameter int WEIGHT_W  = 4,
    parameter int PORT_W    = 3,
    parameter int IN_W      = 3 + ROW_W + COL_W + LEN_W + DATA_W,
    parameter int OUT_W     = 3 + ROW_W + COL_W + DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mc_en,
    input  logic [1:0]                    arb_mode,
    input  logic [PORT_W-1:0]             prio_port,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weights,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    input  logic [NUM_PORTS*IN_W-1:0]     in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [PORT_W-1:0]             out_port,
    output logic                          busy
);

    // Slot count covering every value a PORT_W index can take, so any
    // index (grant, last grant, prio_port) selects a defined entry.
    localparam int NSLOT = 1 << PORT_W;
    localparam int HDR_W = 3 + ROW_W + COL_W;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   grant_q, grant_d;
    logic [PORT_W-1:0]   last_grant_q, last_grant_d;
    logic [WEIGHT_W-1:0] wrr_cnt_q, wrr_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [PORT_W-1:0]   out_port_q, out_port_d;

    logic [NSLOT-1:0]    elig_full;
    logic [IN_W-1:0]     port_data [NSLOT];
    logic [WEIGHT_W-1:0] port_weight [NSLOT];
    logic                len_unused;

    logic [PORT_W-1:0]   fixed_pick, rr_pick;
    logic [WEIGHT_W-1:0] w_eff;
    logic                wrr_stay;
    logic [IN_W-1:0]     cur_beat;
    logic                can_load;
    logic                hs;

    // Unpack the flat port buses into per-port beats, weights and eligibility.
    always_comb begin
        elig_full  = '0;
        len_unused = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            port_data[i]   = '0;
            port_weight[i] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_data[i]   = in_data[i*IN_W +: IN_W];
            port_weight[i] = weights[i*WEIGHT_W +: WEIGHT_W];
            elig_full[i]   = in_valid[i] & in_data[i*IN_W + IN_W - 2];
            len_unused     = len_unused ^ (^in_data[i*IN_W + DATA_W +: LEN_W]);
        end
    end

    // Candidate winners for each arbitration mode; lower scan positions overwrite later ones.
    always_comb begin
        fixed_pick = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (elig_full[i]) fixed_pick = PORT_W'(i);
        end
        rr_pick = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (elig_full[PORT_W'((int'(last_grant_q) + k) % NUM_PORTS)])
                rr_pick = PORT_W'((int'(last_grant_q) + k) % NUM_PORTS);
        end
        w_eff    = (port_weight[last_grant_q] == '0) ? WEIGHT_W'(1) : port_weight[last_grant_q];
        wrr_stay = elig_full[last_grant_q] && (wrr_cnt_q < (w_eff - WEIGHT_W'(1)));
    end

    // Next-state, grant bookkeeping, input ready and output register loading.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wrr_cnt_d    = wrr_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_port_d   = out_port_q;
        in_ready     = '0;
        hs           = 1'b0;
        cur_beat     = port_data[grant_q];
        can_load     = !out_valid_q || out_ready;

        if (out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (mc_en && (|elig_full)) begin
                    state_d = LOCK;
                    case (arb_mode)
                        2'd0: grant_d = fixed_pick;
                        2'd1: grant_d = rr_pick;
                        2'd2: begin
                            if (wrr_stay) begin
                                grant_d   = last_grant_q;
                                wrr_cnt_d = wrr_cnt_q + WEIGHT_W'(1);
                            end else begin
                                grant_d   = rr_pick;
                                wrr_cnt_d = '0;
                            end
                        end
                        default: grant_d = elig_full[prio_port] ? prio_port : rr_pick;
                    endcase
                end
            end
            LOCK: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant_q == PORT_W'(i)) begin
                        in_ready[i] = can_load;
                        hs          = can_load & in_valid[i];
                    end
                end
                if (hs) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {cur_beat[IN_W-1 -: HDR_W], cur_beat[DATA_W-1:0]};
                    out_port_d  = grant_q;
                    if (cur_beat[IN_W-3]) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            wrr_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_port_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wrr_cnt_q    <= wrr_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_port_q   <= out_port_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;
    assign busy      = (state_q == LOCK);

endmodule

// File: doc/frame_arb_mport.md
Name: frame_arb_mport

Overview:
- N-port frame arbiter; parametrised successor to the fixed two-source (write/read) arbiter in the AXI slave front-end.
- Accepts internal frames from NUM_PORTS channel blocks and selects one frame at a time.
- Locks the grant from the sof beat to the eof beat, strips the len field, and drives a registered array-frame output to the array controller.
- Adds four selectable arbitration modes (fixed, round-robin, weighted round-robin, priority-port), frame locking and an output pipeline register.

Parameters:
- NUM_PORTS, 4, number of frame sources (2..8)
- COL_W, 6, array column address width
- ROW_W, 16, array row address width
- LEN_W, 8, burst length field width
- DATA_W, 64, array data width
- WEIGHT_W, 4, per-port WRR weight width
- PORT_W, 3, port index width (>= clog2(NUM_PORTS))
- IN_W, 3+ROW_W+COL_W+LEN_W+DATA_W, input frame width
- OUT_W, 3+ROW_W+COL_W+DATA_W, output frame width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mc_en  in  1  enables new grants
- arb_mode  in  2  0 fixed, 1 RR, 2 WRR, 3 priority-port
- prio_port  in  PORT_W  favoured port for mode 3
- weights  in  NUM_PORTS*WEIGHT_W  per-port WRR weights, port i at bits [i*WEIGHT_W +: WEIGHT_W]
- in_valid  in  NUM_PORTS  frame beat valid per port
- in_ready  out  NUM_PORTS  frame beat ready per port
- in_data  in  NUM_PORTS*IN_W  port i at bits [i*IN_W +: IN_W]; MSB-first layout {rw_flag, sof, eof, row, col, len, data}
- out_valid  out  1  array frame valid
- out_ready  in  1  array frame ready
- out_data  out  OUT_W  {rw_flag, sof, eof, row, col, data}
- out_port  out  PORT_W  source port of out_data
- busy  out  1  high while LOCK

Behaviour:
- Reset: out_valid=0, out_data=0, out_port=0, busy=0, state=IDLE, grant=0, last_grant=NUM_PORTS-1, wrr_cnt=0. in_ready=0 for all ports.
- Eligible port: in_valid[i]=1 and sof=1 in in_data. A valid beat without sof in IDLE is ineligible and is held (in_ready=0) indefinitely.
- IDLE: if mc_en=1 and any port is eligible, register grant and go to LOCK next cycle. Otherwise stay in IDLE.
- Mode 0: lowest eligible index wins.
- Mode 1: first eligible port scanning from last_grant+1, with wrap.
- Mode 2: if last_grant is eligible and wrr_cnt < max(weight[last_grant],1)-1, regrant last_grant and increment wrr_cnt. Otherwise use the RR pick and clear wrr_cnt. A weight of 0 is treated as 1.
- Mode 3: prio_port wins if eligible; otherwise use the RR pick.
- LOCK: in_ready[grant] = (!out_valid | out_ready). All other in_ready bits are 0.
- In LOCK, on in handshake: out_data <= input fields minus len, out_port <= grant, out_valid <= 1.
- On the accepted beat with eof=1: last_grant <= grant, return to IDLE. This gives a one-cycle arbitration bubble between frames.
- Output register: out_valid clears on out_ready when no new beat is loaded in the same cycle. Simultaneous out_ready and new handshake gives back-to-back beats. Throughput is 1 beat/cycle within a frame.
- Latency: sof at IDLE cycle t -> in_ready high at t+1 -> out_valid at t+2, given out_ready=1.
- Frame with sof=1 and eof=1 is a single-beat frame: one transfer, then IDLE.
- mc_en falling during LOCK: the current frame completes, then no new grant is issued.
- Mode, weight or prio_port changes take effect at the next IDLE decision only.
- Reset asserted mid-frame: all state returns to reset values immediately. Any partial frame is discarded; sources must also be reset.
- len is ignored for framing (eof is authoritative).

Test Plan:
- Mode 0: ports 0 and 2 both present a 3-beat frame at once -> port 0 frame beats on out (out_port=0), then port 2; no interleaving.
- Mode 1: all 4 ports continuously present 1-beat frames -> out_port sequence 0,1,2,3,0,…; one bubble cycle between frames.
- Mode 2, weights {1,3,1,1}: ports 1 and 2 continuously valid -> out_port sequence 1,1,1,2,1,1,1,2.
- Mode 3, prio_port=3: ports 0 and 3 valid -> port 3 granted first.
- out_ready held 0 for 5 cycles mid-frame -> out_data stable, in_ready[grant]=0. Release out_ready -> remaining beats delivered with no loss or duplication.
- mc_en=0 with ports valid -> no in_ready. Drop mc_en during a 4-beat frame -> frame completes, busy=0 afterwards, no new grant. Assert rst_n=0 mid-frame -> out_valid=0 on the next edge.
